// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the digital clock.
//   mode_t          : controller state, also driven out on the mode port
//   SEC_W/MIN_W/HR_W: counter widths of the seconds/minutes/hours chain
//   DEF_*           : default timing constants for a 50 MHz system clock
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;

  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 12_500_000;
  localparam int unsigned DEF_BLINK_HALF    = 25_000_000;
  localparam int unsigned DEF_IDLE_TIMEOUT  = 10;

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Press detector with auto-repeat for a debounced level button.
//   clk, rst : system clock, synchronous active-high reset
//   btn_i    : debounced button level, high = pressed
//   clr_i    : abandon the current hold (mode change); repeats stop until
//              the next press
//   pulse_o  : combinational one-cycle pulse on the press cycle, after
//              REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles.
//              The caller registers it.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic clr_i,
  output logic pulse_o
);

  // hold_q == k means the button has been held k cycles since its press;
  // 0 means no hold is being tracked.
  localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY);
  // After a repeat, reload so the next fire is REPEAT_PERIOD cycles later.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic              btn_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              press_w, rep_w;

  assign press_w = btn_i & ~btn_q;
  assign rep_w   = btn_i & (hold_q == HOLD_FIRE);
  assign pulse_o = press_w | rep_w;

  // NOTE: next-state logic assigns hold_d on every path, starting from a
  // default, so no latch is inferred.
  always_comb begin
    hold_d = hold_q;
    if (clr_i || !btn_i) begin
      hold_d = '0;
    end else if (press_w) begin
      hold_d = HOLD_W'(1);
    end else if (rep_w) begin
      hold_d = HOLD_RELOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      btn_q  <= btn_i;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode and time-set controller for the digital clock.
//   clk, rst              : system clock, synchronous active-high reset
//   tick_1s/1m/1h         : prescaler pulse and seconds/minutes carries
//   btn_mode, btn_inc     : debounced button levels
//   sec_en/min_en/hr_en   : registered one-cycle advance strobes
//   sec_clr               : registered one-cycle seconds clear
//   mode                  : 0 RUN, 1 SET_HR, 2 SET_MIN
//   blank_hr/blank_min    : blink control for the field being edited
// RUN forwards the carry chain; SET states freeze it and turn btn_inc
// presses/repeats into strobes for the edited field.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned BLINK_HALF    = DEF_BLINK_HALF,
  parameter int unsigned IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       tick_1m,
  input  logic       tick_1h,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam int unsigned IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  mode_t              mode_q;
  logic               btn_mode_q;
  logic [IDLE_W-1:0]  idle_q;
  logic [BLINK_W-1:0] blink_q;
  logic               sec_en_q, min_en_q, hr_en_q, sec_clr_q;
  logic               blank_hr_q, blank_min_q;

  logic mode_edge, inc_pulse, in_set, timeout, mode_change;

  assign mode_edge = btn_mode & ~btn_mode_q;
  assign in_set    = (mode_q != RUN);
  // A button edge in the same cycle as the final tick keeps us in SET.
  assign timeout   = in_set & tick_1s & (idle_q == IDLE_LAST) & ~mode_edge & ~inc_pulse;
  assign mode_change = mode_edge | timeout;

  btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_inc_repeat (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_inc),
    .clr_i  (mode_change),
    .pulse_o(inc_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= RUN;
      btn_mode_q  <= 1'b0;
      idle_q      <= '0;
      blink_q     <= '0;
      sec_en_q    <= 1'b0;
      min_en_q    <= 1'b0;
      hr_en_q     <= 1'b0;
      sec_clr_q   <= 1'b0;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      sec_en_q   <= 1'b0;
      min_en_q   <= 1'b0;
      hr_en_q    <= 1'b0;
      sec_clr_q  <= 1'b0;

      case (mode_q)
        RUN: begin
          sec_en_q    <= tick_1s;
          min_en_q    <= tick_1m;
          hr_en_q     <= tick_1h;
          blank_hr_q  <= 1'b0;
          blank_min_q <= 1'b0;
          if (mode_edge) begin
            mode_q    <= SET_HR;
            sec_clr_q <= 1'b1;
            idle_q    <= '0;
            blink_q   <= '0;
          end
        end

        default: begin
          // Carries are dropped here: the clock is frozen, and a minutes
          // wrap while setting must not bump the hours.
          if (mode_edge) begin
            mode_q      <= (mode_q == SET_HR) ? SET_MIN : RUN;
            idle_q      <= '0;
            blink_q     <= '0;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
          end else if (inc_pulse) begin
            hr_en_q     <= (mode_q == SET_HR);
            min_en_q    <= (mode_q == SET_MIN);
            idle_q      <= '0;
            blink_q     <= '0;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
          end else if (timeout) begin
            mode_q      <= RUN;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
          end else begin
            if (tick_1s) begin
              idle_q <= idle_q + 1'b1;
            end
            if (blink_q == BLINK_LAST) begin
              blink_q <= '0;
              if (mode_q == SET_HR) begin
                blank_hr_q <= ~blank_hr_q;
              end else begin
                blank_min_q <= ~blank_min_q;
              end
            end else begin
              blink_q <= blink_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign sec_en    = sec_en_q;
  assign min_en    = min_en_q;
  assign hr_en     = hr_en_q;
  assign sec_clr   = sec_clr_q;
  assign mode      = mode_q;
  assign blank_hr  = blank_hr_q;
  assign blank_min = blank_min_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with short timing parameters.
module tb_clock_set_ctrl;

  localparam int RD = 8;
  localparam int RP = 4;
  localparam int BH = 5;
  localparam int IT = 3;

  logic       clk = 1'b0;
  logic       rst, tick_1s, tick_1m, tick_1h, btn_mode, btn_inc;
  logic       sec_en, min_en, hr_en, sec_clr, blank_hr, blank_min;
  logic [1:0] mode;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .BLINK_HALF   (BH),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1s  (tick_1s),
    .tick_1m  (tick_1m),
    .tick_1h  (tick_1h),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hr_en    (hr_en),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .blank_hr (blank_hr),
    .blank_min(blank_min)
  );

  typedef struct packed {
    logic rst, ts, tm, th, bm, bi;
  } in_t;

  // exp packs {sec_en, min_en, hr_en, sec_clr, mode[1:0], blank_hr, blank_min}
  typedef struct {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] outs();
    return {sec_en, min_en, hr_en, sec_clr, mode, blank_hr, blank_min};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    rst      = v.rst;
    tick_1s  = v.ts;
    tick_1m  = v.tm;
    tick_1h  = v.th;
    btn_mode = v.bm;
    btn_inc  = v.bi;
  endtask

  task automatic drive(input logic r, ts, tm, th, bm, bi);
    in_t v;
    v = {r, ts, tm, th, bm, bi};
    apply(v);
  endtask

  // Inputs are sampled at the posedge; outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks: mode, held = cycles since the inc press (-1 = no hold),
  // idle = tick_1s count since last activity, since = cycles since the
  // blink last restarted.
  int m_mode, m_held, m_idle, m_since;
  bit m_pm, m_pi;

  task automatic model_step(input in_t v, output logic [7:0] e);
    bit medge, iedge, rep, inc, tmo;
    bit esec, emin, ehr, eclr, ebhr, ebmin;
    if (v.rst) begin
      m_mode = 0; m_held = -1; m_idle = 0; m_since = 0; m_pm = 0; m_pi = 0;
      e = 8'h00;
      return;
    end
    medge = v.bm && !m_pm;
    iedge = v.bi && !m_pi;
    m_pm  = v.bm;
    m_pi  = v.bi;
    if (iedge) m_held = 0;
    else if (v.bi && m_held >= 0) m_held++;
    else m_held = -1;
    rep = !iedge && m_held >= RD && ((m_held - RD) % RP) == 0;
    inc = iedge || rep;
    {esec, emin, ehr, eclr, tmo} = '0;
    if (m_mode == 0) begin
      esec = v.ts; emin = v.tm; ehr = v.th;
      if (medge) begin m_mode = 1; eclr = 1; m_idle = 0; m_since = 0; end
    end else if (medge) begin
      m_mode = (m_mode == 1) ? 2 : 0; m_idle = 0; m_since = 0;
    end else if (inc) begin
      if (m_mode == 1) ehr = 1; else emin = 1;
      m_idle = 0; m_since = 0;
    end else if (v.ts && m_idle + 1 == IT) begin
      m_mode = 0; tmo = 1;
    end else begin
      if (v.ts) m_idle++;
      m_since++;
    end
    if (medge || tmo) m_held = -1;
    ebhr  = (m_mode == 1) && ((m_since / BH) % 2 == 1);
    ebmin = (m_mode == 2) && ((m_since / BH) % 2 == 1);
    e = {esec, emin, ehr, eclr, 2'(m_mode), ebhr, ebmin};
  endtask

  vec_t tbl[29];

  initial begin
    // watchdog: the run is a fixed number of cycles, so this only trips on a hang
    #2_000_000;
    $display("FAIL watchdog: still running at time %0t, limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    in_t        v;
    logic [7:0] e;
    bit         bm_lvl, bi_lvl;

    //              rst ts tm th bm bi     expected outputs
    tbl[0]  = '{in: 6'b1_0_0_0_0_0, exp: 8'h00};  // reset
    tbl[1]  = '{in: 6'b0_1_1_1_0_0, exp: 8'he0};  // RUN forwards all ticks
    tbl[2]  = '{in: 6'b0_0_0_0_0_0, exp: 8'h00};  // strobes last one cycle
    tbl[3]  = '{in: 6'b0_0_0_0_0_1, exp: 8'h00};  // inc ignored in RUN
    tbl[4]  = '{in: 6'b0_0_0_0_0_0, exp: 8'h00};
    tbl[5]  = '{in: 6'b0_0_0_0_1_0, exp: 8'h14};  // -> SET_HR, sec_clr
    tbl[6]  = '{in: 6'b0_1_0_0_0_0, exp: 8'h04};  // frozen: no sec_en
    tbl[7]  = '{in: 6'b0_0_0_0_0_1, exp: 8'h24};  // inc -> hr_en
    tbl[8]  = '{in: 6'b0_0_0_0_0_0, exp: 8'h04};
    tbl[9]  = '{in: 6'b0_0_0_0_1_1, exp: 8'h08};  // mode+inc: mode wins
    tbl[10] = '{in: 6'b0_0_0_0_0_0, exp: 8'h08};
    tbl[11] = '{in: 6'b0_0_0_0_0_1, exp: 8'h48};  // inc -> min_en
    tbl[12] = '{in: 6'b0_0_0_1_0_0, exp: 8'h08};  // carry suppressed
    tbl[13] = '{in: 6'b0_0_0_0_1_0, exp: 8'h00};  // -> RUN, no clear
    tbl[14] = '{in: 6'b0_1_0_0_0_0, exp: 8'h80};  // counting resumes
    tbl[15] = '{in: 6'b0_0_0_0_1_0, exp: 8'h14};  // -> SET_HR
    tbl[16] = '{in: 6'b0_1_0_0_0_0, exp: 8'h04};  // idle 1
    tbl[17] = '{in: 6'b0_1_0_0_0_0, exp: 8'h04};  // idle 2
    tbl[18] = '{in: 6'b0_1_0_0_0_0, exp: 8'h00};  // timeout -> RUN
    tbl[19] = '{in: 6'b0_1_0_0_0_0, exp: 8'h80};
    tbl[20] = '{in: 6'b0_0_0_0_1_0, exp: 8'h14};  // -> SET_HR
    tbl[21] = '{in: 6'b0_1_0_0_0_0, exp: 8'h04};
    tbl[22] = '{in: 6'b0_1_0_0_0_0, exp: 8'h04};
    tbl[23] = '{in: 6'b0_1_0_0_0_1, exp: 8'h24};  // inc beats timeout
    tbl[24] = '{in: 6'b0_1_0_0_0_0, exp: 8'h04};  // idle restarted
    tbl[25] = '{in: 6'b0_0_0_0_1_0, exp: 8'h08};
    tbl[26] = '{in: 6'b0_0_0_0_0_0, exp: 8'h08};
    tbl[27] = '{in: 6'b0_0_0_0_1_0, exp: 8'h00};
    tbl[28] = '{in: 6'b0_0_0_0_0_0, exp: 8'h00};

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 29; i++) begin
      apply(tbl[i].in);
      step();
      check($sformatf("row%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // ---- held increment in SET_MIN: first press, then repeat after RD, every RP ----
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    check("enter_set_min", 32'(mode), 32'd2);
    for (int k = 0; k < 24; k++) begin
      drive(0, 0, 0, (k == 2), 0, (k < 20));
      step();
      check($sformatf("hold_min_en k=%0d", k), 32'(min_en),
            32'(k == 0 || k == 8 || k == 12 || k == 16));
      check($sformatf("hold_hr_en k=%0d", k), 32'(hr_en), 32'd0);
    end

    // ---- blink in SET_MIN, increment restarts it, reset mid-edit ----
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0); step();
    check("blink_entry_mode", 32'(mode), 32'd2);
    check("blink_entry_blank", 32'(blank_min), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("blink_min n=%0d", n), 32'(blank_min), 32'((n / BH) % 2));
      check($sformatf("blink_hr n=%0d", n), 32'(blank_hr), 32'd0);
    end
    drive(0, 0, 0, 0, 0, 1); step();
    check("blink_inc_strobe", 32'(min_en), 32'd1);
    check("blink_inc_visible", 32'(blank_min), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    for (int m = 1; m <= 6; m++) begin
      step();
      check($sformatf("blink_after_inc m=%0d", m), 32'(blank_min), 32'((m / BH) % 2));
    end
    drive(1, 1, 1, 1, 0, 1); step();
    check("rst_mid_set", 32'(outs()), 32'h00);

    // ---- randomized run against the reference model ----
    bm_lvl = 0;
    bi_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) bm_lvl = ~bm_lvl;
      if ($urandom_range(0, 11) == 0) bi_lvl = ~bi_lvl;
      v.rst = (i == 0) || ($urandom_range(0, 499) == 0);
      v.ts  = ($urandom_range(0, 3) == 0);
      v.tm  = ($urandom_range(0, 9) == 0);
      v.th  = ($urandom_range(0, 9) == 0);
      v.bm  = bm_lvl;
      v.bi  = bi_lvl;
      apply(v);
      model_step(v, e);
      step();
      check($sformatf("rand%0d", i), 32'(outs()), 32'(e));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
